bin2bcd: RTL and testbench

//   Serial binary-to-BCD converter (shift-and-add-3 / "double dabble").

---
 rtl/bin2bcd.sv | 42 ++++
 tb/tb_bin2bcd.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - serial MSB-first binary to packed BCD converter (double dabble)
// Each edge corrects every digit (add 3 when >= 5) then shifts left, pulling in_i into bit 0.
module bin2bcd #(
    parameter int Ndigit = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_i,
    output logic [4*Ndigit-1:0]   out_o
);

    localparam int W = 4 * Ndigit;

    logic [W-1:0] out_q;
    logic [W-1:0] out_d;
    logic [W-1:0] corr;

    // Add-3 precorrection keeps each digit legal BCD after the doubling shift.
    always_comb begin
        corr = '0;
        for (int k = 0; k < Ndigit; k++) begin
            if (out_q[4*k +: 4] >= 4'd5) begin
                corr[4*k +: 4] = out_q[4*k +: 4] + 4'd3;
            end else begin
                corr[4*k +: 4] = out_q[4*k +: 4];
            end
        end
        // The top corrected bit is the carry out of the top digit and is dropped.
        out_d = {corr[W-2:0], in_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: tb/tb_bin2bcd.sv
// tb/tb_bin2bcd.sv - scoreboard bench for bin2bcd with directed serial streams
module tb_bin2bcd;

    localparam int ND = 8;
    localparam int MODV = 100000000;

    logic          clk_i;
    logic          rst_i;
    logic          in_i;
    logic [31:0]   out_o;

    bin2bcd #(.Ndigit(ND)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (in_i),
        .out_o (out_o)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } item_t;

    item_t exp_q[$];
    int    tests;
    int    fails;
    int    vbin;
    int    step;
    logic  vld;
    event  ev_async;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check_pop();
        item_t it;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_underflow: out=%h with no expected entry", out_o);
        end else begin
            it = exp_q.pop_front();
            if (out_o !== it.exp) begin
                fails++;
                $display("FAIL %s: out=%h expected=%h", it.name, out_o, it.exp);
            end
        end
    endtask

    always @(posedge clk_i) begin
        if (vld && !rst_i) begin
            #1;
            check_pop();
        end
    end

    always @(ev_async) begin
        check_pop();
    end

    task automatic push(input string name, input logic [31:0] e);
        item_t it;
        it.name = name;
        it.exp  = e;
        exp_q.push_back(it);
    endtask

    task automatic send_bit(input logic b, input string name, input logic [31:0] e);
        @(negedge clk_i);
        in_i = b;
        vld  = 1'b1;
        step++;
        push($sformatf("%s_%0d", name, step), e);
    endtask

    task automatic send_hand(input logic b, input string name, input logic [31:0] e);
        vbin = (2 * vbin + int'(b)) % MODV;
        send_bit(b, name, e);
    endtask

    task automatic send_model(input logic b, input string name);
        vbin = (2 * vbin + int'(b)) % MODV;
        send_bit(b, name, to_bcd(vbin));
    endtask

    // Assert reset between edges, verify immediate clear and hold, release at a negedge.
    task automatic do_reset(input string name);
        @(negedge clk_i);
        vld  = 1'b0;
        in_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        push({name, "_async"}, 32'h0);
        ->ev_async;
        repeat (3) begin
            @(posedge clk_i);
            #1;
            push({name, "_held"}, 32'h0);
            ->ev_async;
        end
        @(negedge clk_i);
        in_i  = 1'b0;
        rst_i = 1'b0;
        vbin  = 0;
        step  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    logic [31:0] ones8 [8] = '{32'h001, 32'h003, 32'h007, 32'h015,
                               32'h031, 32'h063, 32'h127, 32'h255};
    logic        s12_b [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0};
    logic [31:0] s12_e [12] = '{32'h1, 32'h3, 32'h7, 32'h15, 32'h31, 32'h63,
                                32'h127, 32'h254, 32'h509, 32'h1018, 32'h2037, 32'h4074};
    logic [31:0] z3_e [3]   = '{32'h8148, 32'h16296, 32'h32592};

    initial begin
        tests = 0;
        fails = 0;
        vbin  = 0;
        step  = 0;
        vld   = 1'b0;
        in_i  = 1'b0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        push("reset_initial", 32'h0);
        ->ev_async;
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) send_hand(1'b1, "ones8", ones8[i]);

        do_reset("rst_after_ones8");
        for (int i = 0; i < 12; i++) send_hand(s12_b[i], "stream12", s12_e[i]);
        for (int i = 0; i < 3; i++) send_hand(1'b0, "zeros", z3_e[i]);
        for (int i = 3; i < 16; i++) send_model(1'b0, "zeros");
        send_hand(1'b0, "wrap17", 32'h33987328);

        do_reset("rst_after_wrap");
        for (int i = 0; i < 23; i++) send_model(1'b1, "ones24");
        send_hand(1'b1, "max24", 32'h16777215);
        send_hand(1'b1, "max25", 32'h33554431);

        do_reset("rst_before_mid");
        send_model(1'b1, "pre_mid");
        send_model(1'b0, "pre_mid");
        send_model(1'b1, "pre_mid");
        send_model(1'b1, "pre_mid");
        send_model(1'b0, "pre_mid");
        do_reset("rst_mid");
        send_hand(1'b1, "post_mid", 32'h1);
        send_hand(1'b0, "post_mid", 32'h2);
        send_hand(1'b1, "post_mid", 32'h5);

        do_reset("rst_mix");
        send_hand(1'b1, "mix", 32'h1);
        send_hand(1'b0, "mix", 32'h2);
        send_hand(1'b0, "mix", 32'h4);
        send_hand(1'b1, "mix", 32'h9);
        send_hand(1'b1, "mix", 32'h19);
        send_hand(1'b0, "mix", 32'h38);
        send_hand(1'b1, "mix", 32'h77);

        @(negedge clk_i);
        vld = 1'b0;
        repeat (2) @(negedge clk_i);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
